// File: rtl/mod_n_pkg.sv
// Shared types for the mod-N count decoder: tracking FSM states and step classes.
// Kept in one package so the classifier and the top agree on encodings.
package mod_n_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ACQ   = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_ILL  = 2'd3
    } step_t;

    // True for steps that move the count (and so carry a direction).
    function automatic logic is_move(step_t s);
        return (s == STEP_UP) || (s == STEP_DOWN);
    endfunction

endpackage

// File: rtl/mod_n_step_classify.sv
// Combinational classifier: compares a new mod-N sample q with the previous one p
// and reports HOLD/UP/DOWN/ILL plus whether the step crossed the modulus boundary.
module mod_n_step_classify
    import mod_n_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int N     = 3
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    output step_t            step,
    output logic             wrap,
    output logic             in_range
);

    // One extra bit so N == 2**WIDTH is representable without overflow.
    localparam logic [WIDTH:0] N_EXT = (WIDTH + 1)'(N);
    localparam logic [WIDTH:0] LAST  = (WIDTH + 1)'(N - 1);

    logic [WIDTH:0] p_ext;
    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] inc_p;
    logic [WIDTH:0] dec_p;

    assign p_ext = {1'b0, p};
    assign q_ext = {1'b0, q};

    // NOTE: every output of this always_comb gets a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        inc_p    = (p_ext == LAST) ? '0 : p_ext + 1'b1;
        dec_p    = (p_ext == '0) ? LAST : p_ext - 1'b1;
        in_range = (q_ext < N_EXT);
        step     = STEP_ILL;
        wrap     = 1'b0;

        // Priority order matters for N == 2, where inc(p) == dec(p): UP wins.
        if (!in_range) begin
            step = STEP_ILL;
        end else if (q_ext == p_ext) begin
            step = STEP_HOLD;
        end else if (q_ext == inc_p) begin
            step = STEP_UP;
            wrap = (p_ext == LAST);
        end else if (q_ext == dec_p) begin
            step = STEP_DOWN;
            wrap = (p_ext == '0);
        end
    end

endmodule

// File: rtl/mod_n_count_decoder.sv
// Observer for a mod-N up/down counter link: recovers enable/direction from the
// sampled count, flags wraps and illegal steps, and tracks lock on the stream.
module mod_n_count_decoder
    import mod_n_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int N        = 3,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_Q,
    input  logic             i_clr,
    output logic             o_valid,
    output logic             o_en,
    output logic             o_up_down,
    output logic             o_wrap,
    output logic             o_err,
    output logic             o_err_sticky,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_wrap_cnt
);

    localparam int                GOOD_W   = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_CNT);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [GOOD_W-1:0] good_q, good_d;

    logic              valid_d, en_d, wrap_d, err_d, up_down_d, sticky_d;
    logic [CNT_W-1:0]  wrap_base, wrap_cnt_d;

    step_t             step;
    logic              step_wrap;
    logic              q_in_range;

    mod_n_step_classify #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_classify (
        .p        (prev_q),
        .q        (i_Q),
        .step     (step),
        .wrap     (step_wrap),
        .in_range (q_in_range)
    );

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        good_d    = good_q;
        valid_d   = 1'b0;
        en_d      = 1'b0;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        up_down_d = o_up_down;

        if (i_valid) begin
            if (q_in_range) begin
                prev_d = i_Q;
            end

            if (state_q == S_EMPTY) begin
                // First usable sample only becomes the reference; nothing to classify.
                if (q_in_range) begin
                    good_d  = '0;
                    state_d = S_ACQ;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                valid_d = 1'b1;
                if (step == STEP_ILL) begin
                    err_d   = 1'b1;
                    good_d  = '0;
                    state_d = q_in_range ? S_ACQ : S_EMPTY;
                end else begin
                    en_d   = is_move(step);
                    wrap_d = step_wrap;
                    if (en_d) begin
                        up_down_d = (step == STEP_UP);
                    end
                    // good_q stays below LOCK_CNT while acquiring, so it cannot overflow.
                    if (state_q == S_ACQ) begin
                        good_d = good_q + 1'b1;
                        if (good_d >= LOCK_TGT) begin
                            state_d = S_LOCK;
                        end
                    end
                end
            end
        end

        // A clear lands before this cycle's event, so the event still registers.
        sticky_d   = (o_err_sticky & ~i_clr) | err_d;
        wrap_base  = i_clr ? '0 : o_wrap_cnt;
        wrap_cnt_d = (wrap_d && (wrap_base != '1)) ? wrap_base + 1'b1 : wrap_base;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_EMPTY;
            prev_q       <= '0;
            good_q       <= '0;
            o_valid      <= 1'b0;
            o_en         <= 1'b0;
            o_up_down    <= 1'b1;
            o_wrap       <= 1'b0;
            o_err        <= 1'b0;
            o_err_sticky <= 1'b0;
            o_locked     <= 1'b0;
            o_wrap_cnt   <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_q       <= good_d;
            o_valid      <= valid_d;
            o_en         <= en_d;
            o_up_down    <= up_down_d;
            o_wrap       <= wrap_d;
            o_err        <= err_d;
            o_err_sticky <= sticky_d;
            o_locked     <= (state_d == S_LOCK);
            o_wrap_cnt   <= wrap_cnt_d;
        end
    end

endmodule

// File: tb/tb_mod_n_count_decoder.sv
// Self-checking bench for mod_n_count_decoder: three instances (N=3, N=5 with a
// 2-bit wrap counter, N=2 == 2**WIDTH) driven through a reference-model scoreboard.
module tb_mod_n_count_decoder;
    import mod_n_pkg::*;

    typedef struct packed {
        logic       valid;
        logic       en;
        logic       up_down;
        logic       wrap;
        logic       err;
        logic       sticky;
        logic       locked;
        logic [7:0] wrap_cnt;
    } obs_t;

    typedef struct {
        int   inst;
        obs_t exp;
    } sb_t;

    logic       i_clk;
    logic       rst;
    logic [2:0] v;
    logic [2:0] clr;
    logic [1:0] qa;
    logic [2:0] qb;
    logic [0:0] qc;
    logic [2:0] ov, oen, oud, owr, oer, ost, olk;
    logic [7:0] wc_a;
    logic [1:0] wc_b;
    logic [7:0] wc_c;

    int n_checks = 0;
    int n_fail   = 0;

    sb_t sbq[$];

    // Reference model state, one slot per instance.
    int p_n[3]    = '{3, 5, 2};
    int p_lock[3] = '{2, 2, 1};
    int p_max[3]  = '{255, 3, 255};
    int m_state[3];
    int m_prev[3];
    int m_good[3];
    int m_wc[3];
    bit m_ud[3];
    bit m_sticky[3];

    mod_n_count_decoder #(.WIDTH(2), .N(3), .LOCK_CNT(2), .CNT_W(8)) dut_a (
        .i_clk(i_clk), .i_rst(rst), .i_valid(v[0]), .i_Q(qa), .i_clr(clr[0]),
        .o_valid(ov[0]), .o_en(oen[0]), .o_up_down(oud[0]), .o_wrap(owr[0]),
        .o_err(oer[0]), .o_err_sticky(ost[0]), .o_locked(olk[0]), .o_wrap_cnt(wc_a)
    );

    mod_n_count_decoder #(.WIDTH(3), .N(5), .LOCK_CNT(2), .CNT_W(2)) dut_b (
        .i_clk(i_clk), .i_rst(rst), .i_valid(v[1]), .i_Q(qb), .i_clr(clr[1]),
        .o_valid(ov[1]), .o_en(oen[1]), .o_up_down(oud[1]), .o_wrap(owr[1]),
        .o_err(oer[1]), .o_err_sticky(ost[1]), .o_locked(olk[1]), .o_wrap_cnt(wc_b)
    );

    mod_n_count_decoder #(.WIDTH(1), .N(2), .LOCK_CNT(1), .CNT_W(8)) dut_c (
        .i_clk(i_clk), .i_rst(rst), .i_valid(v[2]), .i_Q(qc), .i_clr(clr[2]),
        .o_valid(ov[2]), .o_en(oen[2]), .o_up_down(oud[2]), .o_wrap(owr[2]),
        .o_err(oer[2]), .o_err_sticky(ost[2]), .o_locked(olk[2]), .o_wrap_cnt(wc_c)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic obs_t get_obs(int k);
        obs_t o;
        o.valid   = ov[k];
        o.en      = oen[k];
        o.up_down = oud[k];
        o.wrap    = owr[k];
        o.err     = oer[k];
        o.sticky  = ost[k];
        o.locked  = olk[k];
        case (k)
            0:       o.wrap_cnt = wc_a;
            1:       o.wrap_cnt = {6'b0, wc_b};
            default: o.wrap_cnt = wc_c;
        endcase
        return o;
    endfunction

    // Spec-level model of one cycle for instance j; returns the outputs expected next cycle.
    task automatic model_step(input int j, input bit r, input bit vv, input int q,
                              input bit cc, output obs_t e);
        bit inr, up, dn, ill;
        int n;
        n = p_n[j];
        e = '0;
        if (r) begin
            m_state[j] = 0; m_prev[j] = 0; m_good[j] = 0;
            m_ud[j] = 1'b1; m_sticky[j] = 1'b0; m_wc[j] = 0;
            e.up_down = 1'b1;
        end else begin
            if (vv) begin
                inr = (q < n);
                if (m_state[j] == 0) begin
                    if (inr) begin
                        m_good[j]  = 0;
                        m_state[j] = 1;
                    end else begin
                        e.err = 1'b1;
                    end
                end else begin
                    e.valid = 1'b1;
                    up  = inr && (q != m_prev[j]) && (q == (m_prev[j] + 1) % n);
                    dn  = inr && (q != m_prev[j]) && !up && (q == (m_prev[j] + n - 1) % n);
                    ill = !inr || ((q != m_prev[j]) && !up && !dn);
                    if (ill) begin
                        e.err      = 1'b1;
                        m_good[j]  = 0;
                        m_state[j] = inr ? 1 : 0;
                    end else begin
                        if (up || dn) begin
                            e.en    = 1'b1;
                            m_ud[j] = up;
                        end
                        e.wrap = (up && q == 0) || (dn && q == n - 1);
                        if (m_state[j] == 1) begin
                            m_good[j]++;
                            if (m_good[j] >= p_lock[j]) m_state[j] = 2;
                        end
                    end
                end
                if (inr) m_prev[j] = q;
            end
            if (cc) begin
                m_sticky[j] = 1'b0;
                m_wc[j]     = 0;
            end
            if (e.err) m_sticky[j] = 1'b1;
            if (e.wrap && m_wc[j] < p_max[j]) m_wc[j]++;
            e.up_down  = m_ud[j];
            e.sticky   = m_sticky[j];
            e.locked   = (m_state[j] == 2);
            e.wrap_cnt = 8'(m_wc[j]);
        end
    endtask

    // Drive one cycle: stimulus for instance k, others idle; expectations go to the scoreboard.
    task automatic tick(input bit r, input int k, input bit vv, input int q, input bit cc);
        obs_t e;
        @(negedge i_clk);
        rst = r;
        v   = '0;
        clr = '0;
        v[k]   = vv;
        clr[k] = cc;
        case (k)
            0:       qa = q[1:0];
            1:       qb = q[2:0];
            default: qc = q[0:0];
        endcase
        for (int j = 0; j < 3; j++) begin
            model_step(j, r, (j == k) && vv, q, (j == k) && cc, e);
            sbq.push_back('{inst: j, exp: e});
        end
        @(posedge i_clk);
        #2;
    endtask

    // Scoreboard: pop and compare every expectation pushed for this edge.
    sb_t  mon_s;
    obs_t mon_got;
    always @(posedge i_clk) begin
        #1;
        while (sbq.size() > 0) begin
            mon_s   = sbq.pop_front();
            mon_got = get_obs(mon_s.inst);
            n_checks++;
            if (mon_got !== mon_s.exp) begin
                n_fail++;
                $display("FAIL sb inst%0d t=%0t got v/en/ud/wr/er/st/lk=%b%b%b%b%b%b%b cnt=%0d exp %b%b%b%b%b%b%b cnt=%0d",
                         mon_s.inst, $time,
                         mon_got.valid, mon_got.en, mon_got.up_down, mon_got.wrap,
                         mon_got.err, mon_got.sticky, mon_got.locked, mon_got.wrap_cnt,
                         mon_s.exp.valid, mon_s.exp.en, mon_s.exp.up_down, mon_s.exp.wrap,
                         mon_s.exp.err, mon_s.exp.sticky, mon_s.exp.locked, mon_s.exp.wrap_cnt);
            end
        end
    end

    task automatic test_reset();
        obs_t g;
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 1, 2, 0);
        g = get_obs(0);
        n_checks++;
        if (g.locked !== 1'b1) begin
            n_fail++; $display("FAIL reset_prelock got=%b exp=1", g.locked);
        end
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        g = get_obs(0);
        n_checks++;
        if (g !== obs_t'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0})) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=%h", g,
                               obs_t'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));
        end
        tick(0, 0, 1, 1, 0);
        g = get_obs(0);
        n_checks++;
        if (g.valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_first_sample_valid got=%b exp=0", g.valid);
        end
        // Out-of-range first sample on N=3: error pulse, still no reference.
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 3, 0);
        g = get_obs(0);
        n_checks++;
        if (g.err !== 1'b1 || g.valid !== 1'b0) begin
            n_fail++; $display("FAIL empty_oor got err=%b valid=%b exp err=1 valid=0", g.err, g.valid);
        end
    endtask

    task automatic test_count_up();
        int   seq[5] = '{0, 1, 2, 0, 1};
        obs_t g;
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 1, seq[i], 0);
            g = get_obs(0);
            if (i >= 1) begin
                n_checks++;
                if (g.en !== 1'b1 || g.up_down !== 1'b1) begin
                    n_fail++; $display("FAIL up_en_dir s%0d got en=%b ud=%b exp 1 1", i, g.en, g.up_down);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (g.locked !== 1'b1) begin
                    n_fail++; $display("FAIL up_lock got=%b exp=1", g.locked);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (g.wrap !== 1'b1 || g.wrap_cnt !== 8'd1) begin
                    n_fail++; $display("FAIL up_wrap got wrap=%b cnt=%0d exp 1 1", g.wrap, g.wrap_cnt);
                end
            end
        end
    endtask

    task automatic test_count_down();
        int   seq[4] = '{2, 1, 0, 2};
        obs_t g;
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, seq[i], 0);
        g = get_obs(0);
        n_checks++;
        if (g.up_down !== 1'b0 || g.wrap !== 1'b1 || g.wrap_cnt !== 8'd1 || g.sticky !== 1'b0) begin
            n_fail++; $display("FAIL down_wrap got ud=%b wrap=%b cnt=%0d st=%b exp 0 1 1 0",
                               g.up_down, g.wrap, g.wrap_cnt, g.sticky);
        end
    endtask

    task automatic test_hold_gaps();
        obs_t g;
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 2, 0);
        tick(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 1, 0);
            g = get_obs(0);
            n_checks++;
            if (g.valid !== 1'b1 || g.en !== 1'b0 || g.up_down !== 1'b0) begin
                n_fail++; $display("FAIL hold s%0d got v=%b en=%b ud=%b exp 1 0 0", i, g.valid, g.en, g.up_down);
            end
            tick(0, 0, 0, 1, 0);
            g = get_obs(0);
            n_checks++;
            if ({g.valid, g.en, g.wrap, g.err} !== 4'b0000) begin
                n_fail++; $display("FAIL gap s%0d got pulses=%b exp 0000", i, {g.valid, g.en, g.wrap, g.err});
            end
        end
    endtask

    task automatic test_illegal();
        obs_t g;
        tick(1, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 0);
        tick(0, 1, 1, 1, 0);
        tick(0, 1, 1, 3, 0);
        g = get_obs(1);
        n_checks++;
        if (g.err !== 1'b1 || g.sticky !== 1'b1 || g.locked !== 1'b0 || dut_b.state_q !== S_ACQ) begin
            n_fail++; $display("FAIL ill_jump got err=%b st=%b lk=%b state=%0d exp 1 1 0 %0d",
                               g.err, g.sticky, g.locked, dut_b.state_q, S_ACQ);
        end
        tick(0, 1, 1, 7, 0);
        g = get_obs(1);
        n_checks++;
        if (g.err !== 1'b1 || dut_b.state_q !== S_EMPTY || dut_b.prev_q !== 3'd3) begin
            n_fail++; $display("FAIL ill_oor got err=%b state=%0d prev=%0d exp 1 %0d 3",
                               g.err, dut_b.state_q, dut_b.prev_q, S_EMPTY);
        end
        tick(0, 1, 1, 7, 0);
        tick(0, 1, 1, 4, 0);
        g = get_obs(1);
        n_checks++;
        if (g.valid !== 1'b0 || g.sticky !== 1'b1) begin
            n_fail++; $display("FAIL ill_reacquire got v=%b st=%b exp 0 1", g.valid, g.sticky);
        end
    endtask

    task automatic test_wrap_sat();
        int   seq[5] = '{0, 4, 0, 4, 0};
        obs_t g;
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 1, seq[i], 0);
        tick(0, 1, 1, 0, 0);
        g = get_obs(1);
        n_checks++;
        if (g.wrap_cnt !== 8'd3) begin
            n_fail++; $display("FAIL wrap_sat got=%0d exp=3", g.wrap_cnt);
        end
        tick(0, 1, 1, 2, 0);
        tick(0, 1, 1, 3, 0);
        tick(0, 1, 1, 4, 0);
        tick(0, 1, 1, 0, 1);
        g = get_obs(1);
        n_checks++;
        if (g.wrap_cnt !== 8'd1 || g.sticky !== 1'b0) begin
            n_fail++; $display("FAIL clr_with_wrap got cnt=%0d st=%b exp 1 0", g.wrap_cnt, g.sticky);
        end
        tick(0, 1, 1, 2, 1);
        g = get_obs(1);
        n_checks++;
        if (g.sticky !== 1'b1 || g.wrap_cnt !== 8'd0) begin
            n_fail++; $display("FAIL clr_with_err got st=%b cnt=%0d exp 1 0", g.sticky, g.wrap_cnt);
        end
    endtask

    task automatic test_n2();
        obs_t g;
        tick(1, 2, 0, 0, 0);
        tick(0, 2, 1, 0, 0);
        tick(0, 2, 1, 1, 0);
        g = get_obs(2);
        n_checks++;
        if (g.locked !== 1'b1 || g.wrap !== 1'b0) begin
            n_fail++; $display("FAIL n2_lock got lk=%b wrap=%b exp 1 0", g.locked, g.wrap);
        end
        tick(0, 2, 1, 0, 0);
        g = get_obs(2);
        n_checks++;
        if (g.en !== 1'b1 || g.up_down !== 1'b1 || g.wrap !== 1'b1 || g.wrap_cnt !== 8'd1) begin
            n_fail++; $display("FAIL n2_up_wins got en=%b ud=%b wrap=%b cnt=%0d exp 1 1 1 1",
                               g.en, g.up_down, g.wrap, g.wrap_cnt);
        end
        tick(0, 2, 1, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        v   = '0;
        clr = '0;
        qa  = '0;
        qb  = '0;
        qc  = '0;
        test_reset();
        test_count_up();
        test_count_down();
        test_hold_gaps();
        test_illegal();
        test_wrap_sat();
        test_n2();
        tick(0, 0, 0, 0, 0);
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++; $display("FAIL sb_drain got=%0d exp=0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
